// File: rtl/reorder_buffer_ooo.sv
// Circular reorder buffer: in-order allocate, multi-port CDB writeback with
// operand bypass, in-order retire with branch flush and store handshake.
module reorder_buffer_ooo #(
  parameter int unsigned ROB_BITS  = 4,
  parameter int unsigned CDB_PORTS = 2,
  parameter int unsigned XLEN      = 32
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          issue_valid,
  input  logic [1:0]                    issue_type,
  input  logic [4:0]                    issue_rd,
  input  logic                          issue_pred_taken,
  input  logic [XLEN-1:0]               issue_redirect_pc,
  output logic [ROB_BITS-1:0]           rob_tail,
  output logic                          rob_full,
  output logic                          rob_empty,
  input  logic [CDB_PORTS-1:0]          wb_valid,
  input  logic [CDB_PORTS*ROB_BITS-1:0] wb_id,
  input  logic [CDB_PORTS*XLEN-1:0]     wb_value,
  input  logic [ROB_BITS-1:0]           q1_id,
  input  logic [ROB_BITS-1:0]           q2_id,
  output logic                          q1_ready,
  output logic                          q2_ready,
  output logic [XLEN-1:0]               q1_value,
  output logic [XLEN-1:0]               q2_value,
  output logic                          commit_valid,
  output logic [4:0]                    commit_rd,
  output logic [XLEN-1:0]               commit_value,
  output logic [ROB_BITS-1:0]           commit_id,
  output logic                          store_commit,
  input  logic                          store_done,
  output logic                          flush,
  output logic [XLEN-1:0]               flush_pc,
  output logic                          halt
);

  localparam int unsigned SIZE  = 1 << ROB_BITS;
  localparam int unsigned CNT_W = ROB_BITS + 1;

  localparam logic [1:0] T_REG    = 2'd0;
  localparam logic [1:0] T_BRANCH = 2'd1;
  localparam logic [1:0] T_STORE  = 2'd2;
  localparam logic [1:0] T_HALT   = 2'd3;

  logic [1:0]          r_type     [SIZE];
  logic [4:0]          r_rd       [SIZE];
  logic                r_pred     [SIZE];
  logic [XLEN-1:0]     r_redirect [SIZE];
  logic [XLEN-1:0]     r_value    [SIZE];
  logic [SIZE-1:0]     r_ready;

  logic [ROB_BITS-1:0] r_head;
  logic [ROB_BITS-1:0] r_tail;
  logic [CNT_W-1:0]    r_count;

  logic                r_commit_valid;
  logic [4:0]          r_commit_rd;
  logic [XLEN-1:0]     r_commit_value;
  logic [ROB_BITS-1:0] r_commit_id;
  logic                r_store_commit;
  logic                r_flush;
  logic [XLEN-1:0]     r_flush_pc;
  logic                r_halt;

  logic [ROB_BITS-1:0] w_wb_id  [CDB_PORTS];
  logic [XLEN-1:0]     w_wb_val [CDB_PORTS];
  logic [SIZE-1:0]     w_alloc;
  logic [ROB_BITS-1:0] w_off;
  logic                w_full;
  logic                w_issue_fire;
  logic                w_head_ready;
  logic [1:0]          w_head_type;
  logic                w_commit_fire;
  logic                w_mispredict;
  logic [XLEN:0]       w_q1;
  logic [XLEN:0]       w_q2;

  always_comb begin
    for (int p = 0; p < int'(CDB_PORTS); p++) begin
      w_wb_id[p]  = wb_id[p*ROB_BITS +: ROB_BITS];
      w_wb_val[p] = wb_value[p*XLEN +: XLEN];
    end
  end

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    w_alloc = '0;
    w_off   = '0;
    for (int i = 0; i < int'(SIZE); i++) begin
      w_off      = ROB_BITS'(i) - r_head;
      w_alloc[i] = {1'b0, w_off} < r_count;
    end
  end

  // Lowest-indexed matching CDB port overrides the stored entry.
  function automatic logic [XLEN:0] f_lookup(input logic [ROB_BITS-1:0] id);
    logic [XLEN:0] res;
    res = '0;
    if (w_alloc[id]) begin
      res = {r_ready[id], r_value[id]};
      for (int p = int'(CDB_PORTS) - 1; p >= 0; p--) begin
        if (wb_valid[p] && (w_wb_id[p] == id)) res = {1'b1, w_wb_val[p]};
      end
    end
    return res;
  endfunction

  always_comb begin
    w_q1 = f_lookup(q1_id);
    w_q2 = f_lookup(q2_id);
  end

  assign {q1_ready, q1_value} = w_q1;
  assign {q2_ready, q2_value} = w_q2;

  always_comb begin
    w_full        = (r_count == CNT_W'(SIZE));
    w_issue_fire  = issue_valid && !w_full;
    w_head_type   = r_type[r_head];
    w_head_ready  = (r_count != '0) && r_ready[r_head] && !r_halt;
    w_commit_fire = w_head_ready && ((w_head_type != T_STORE) || store_done);
    w_mispredict  = w_commit_fire && (w_head_type == T_BRANCH) &&
                    (r_value[r_head][0] != r_pred[r_head]);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_ready        <= '0;
      r_commit_valid <= 1'b0;
      r_commit_rd    <= '0;
      r_commit_value <= '0;
      r_commit_id    <= '0;
      r_store_commit <= 1'b0;
      r_flush        <= 1'b0;
      r_flush_pc     <= '0;
      r_halt         <= 1'b0;
    end else if (!rdy_in) begin
      r_commit_valid <= 1'b0;
      r_flush        <= 1'b0;
    end else begin
      r_commit_valid <= 1'b0;
      r_flush        <= 1'b0;
      r_store_commit <= w_head_ready && (w_head_type == T_STORE) && !store_done;
      if (w_commit_fire) begin
        r_commit_valid <= 1'b1;
        r_commit_id    <= r_head;
        r_commit_rd    <= (w_head_type == T_REG) ? r_rd[r_head] : 5'd0;
        r_commit_value <= r_value[r_head];
        if (w_head_type == T_HALT) r_halt <= 1'b1;
      end
      if (w_mispredict) begin
        r_flush    <= 1'b1;
        r_flush_pc <= r_redirect[r_head];
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
        r_ready    <= '0;
      end else begin
        if (w_issue_fire) begin
          r_type[r_tail]     <= issue_type;
          r_rd[r_tail]       <= issue_rd;
          r_pred[r_tail]     <= issue_pred_taken;
          r_redirect[r_tail] <= issue_redirect_pc;
          r_value[r_tail]    <= '0;
          r_ready[r_tail]    <= (issue_type == T_STORE);
          r_tail             <= r_tail + 1'b1;
        end
        // Descending order so the lowest port's write lands last.
        for (int p = int'(CDB_PORTS) - 1; p >= 0; p--) begin
          if (wb_valid[p] && w_alloc[w_wb_id[p]]) begin
            r_ready[w_wb_id[p]] <= 1'b1;
            r_value[w_wb_id[p]] <= w_wb_val[p];
          end
        end
        if (w_commit_fire) r_head <= r_head + 1'b1;
        r_count <= r_count + CNT_W'(w_issue_fire) - CNT_W'(w_commit_fire);
      end
    end
  end

  assign rob_tail     = r_tail;
  assign rob_full     = w_full;
  assign rob_empty    = (r_count == '0);
  assign commit_valid = r_commit_valid;
  assign commit_rd    = r_commit_rd;
  assign commit_value = r_commit_value;
  assign commit_id    = r_commit_id;
  assign store_commit = r_store_commit;
  assign flush        = r_flush;
  assign flush_pc     = r_flush_pc;
  assign halt         = r_halt;

endmodule

// File: tb/tb_reorder_buffer_ooo.sv
// Directed bench for reorder_buffer_ooo: ordering, full/wrap, flush, bypass,
// store handshake, stall and halt.
module tb_reorder_buffer_ooo;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        issue_valid;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic        issue_pred_taken;
  logic [31:0] issue_redirect_pc;
  logic [3:0]  rob_tail;
  logic        rob_full, rob_empty;
  logic [1:0]  wb_valid;
  logic [7:0]  wb_id;
  logic [63:0] wb_value;
  logic [3:0]  q1_id, q2_id;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_value, q2_value;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic [3:0]  commit_id;
  logic        store_commit, store_done;
  logic        flush;
  logic [31:0] flush_pc;
  logic        halt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_in = ~clk_in;

  reorder_buffer_ooo dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pred_taken(issue_pred_taken), .issue_redirect_pc(issue_redirect_pc),
    .rob_tail(rob_tail), .rob_full(rob_full), .rob_empty(rob_empty),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value),
    .q1_id(q1_id), .q2_id(q2_id), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_value(q1_value), .q2_value(q2_value),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_value(commit_value), .commit_id(commit_id),
    .store_commit(store_commit), .store_done(store_done),
    .flush(flush), .flush_pc(flush_pc), .halt(halt)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1; rdy_in = 1'b1; issue_valid = 1'b0; issue_type = 2'd0;
    issue_rd = 5'd0; issue_pred_taken = 1'b0; issue_redirect_pc = 32'd0;
    wb_valid = 2'b00; wb_id = 8'd0; wb_value = 64'd0;
    q1_id = 4'd0; q2_id = 4'd0; store_done = 1'b0;
    tick(); tick();
    rst_in = 1'b0;
  endtask

  task automatic do_issue(input logic [1:0] t, input logic [4:0] rd,
                          input logic pred, input logic [31:0] pc);
    issue_valid = 1'b1; issue_type = t; issue_rd = rd;
    issue_pred_taken = pred; issue_redirect_pc = pc;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (rob_empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", rob_empty); else n_pass++;
    n_checks++; if (rob_full !== 1'b0) $display("FAIL reset_full got %b exp 0", rob_full); else n_pass++;
    n_checks++; if (rob_tail !== 4'd0) $display("FAIL reset_tail got %0d exp 0", rob_tail); else n_pass++;
    n_checks++; if ({commit_valid, flush, halt, store_commit} !== 4'b0000)
      $display("FAIL reset_outputs got %b exp 0000", {commit_valid, flush, halt, store_commit}); else n_pass++;
    n_checks++; if (q1_ready !== 1'b0) $display("FAIL reset_q1_ready got %b exp 0", q1_ready); else n_pass++;
  endtask

  task automatic test_inorder_commit();
    logic [4:0]  exp_rd  [3] = '{5'd1, 5'd2, 5'd3};
    logic [31:0] exp_val [3] = '{32'h00, 32'h11, 32'h22};
    do_reset();
    for (int i = 0; i < 3; i++) do_issue(2'd0, 5'(i + 1), 1'b0, 32'd0);
    n_checks++; if (rob_tail !== 4'd3) $display("FAIL order_tail got %0d exp 3", rob_tail); else n_pass++;
    wb_valid = 2'b01; wb_id = {4'd0, 4'd2}; wb_value = {32'd0, 32'h22};
    tick();
    n_checks++; if (commit_valid !== 1'b0) $display("FAIL order_early_commit got %b exp 0", commit_valid); else n_pass++;
    wb_id = {4'd0, 4'd0}; wb_value = {32'd0, 32'h00};
    tick();
    wb_id = {4'd0, 4'd1}; wb_value = {32'd0, 32'h11};
    tick();
    wb_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (commit_valid !== 1'b1 || commit_rd !== exp_rd[i] || commit_value !== exp_val[i])
        $display("FAIL order_commit%0d got v=%b rd=%0d val=%h exp v=1 rd=%0d val=%h",
                 i, commit_valid, commit_rd, commit_value, exp_rd[i], exp_val[i]);
      else n_pass++;
      tick();
    end
    n_checks++; if (commit_valid !== 1'b0 || rob_empty !== 1'b1)
      $display("FAIL order_drained got v=%b empty=%b exp 0/1", commit_valid, rob_empty); else n_pass++;
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) do_issue(2'd0, 5'(i + 1), 1'b0, 32'd0);
    n_checks++; if (rob_full !== 1'b1 || rob_tail !== 4'd0)
      $display("FAIL full_after16 got full=%b tail=%0d exp 1/0", rob_full, rob_tail); else n_pass++;
    do_issue(2'd0, 5'd20, 1'b0, 32'd0);
    n_checks++; if (rob_full !== 1'b1 || rob_tail !== 4'd0)
      $display("FAIL full_ignored got full=%b tail=%0d exp 1/0", rob_full, rob_tail); else n_pass++;
    wb_valid = 2'b11; wb_id = {4'd1, 4'd0}; wb_value = {32'hB1, 32'hB0};
    tick();
    wb_valid = 2'b00;
    issue_valid = 1'b1; issue_type = 2'd0; issue_rd = 5'd21;
    tick();
    n_checks++; if (commit_id !== 4'd0 || commit_valid !== 1'b1 || rob_tail !== 4'd0 || rob_full !== 1'b0)
      $display("FAIL full_gated got id=%0d v=%b tail=%0d full=%b exp 0/1/0/0",
               commit_id, commit_valid, rob_tail, rob_full); else n_pass++;
    tick();
    n_checks++; if (commit_id !== 4'd1 || commit_value !== 32'hB1 || rob_tail !== 4'd1 || rob_full !== 1'b0)
      $display("FAIL full_concurrent got id=%0d val=%h tail=%0d full=%b exp 1/b1/1/0",
               commit_id, commit_value, rob_tail, rob_full); else n_pass++;
    tick();
    issue_valid = 1'b0;
    n_checks++; if (rob_full !== 1'b1 || rob_tail !== 4'd2 || commit_valid !== 1'b0)
      $display("FAIL full_refill got full=%b tail=%0d v=%b exp 1/2/0", rob_full, rob_tail, commit_valid); else n_pass++;
  endtask

  task automatic test_mispredict();
    do_reset();
    do_issue(2'd1, 5'd0, 1'b1, 32'h1004);
    do_issue(2'd0, 5'd5, 1'b0, 32'd0);
    do_issue(2'd0, 5'd6, 1'b0, 32'd0);
    wb_valid = 2'b11; wb_id = {4'd1, 4'd0}; wb_value = {32'h55, 32'h0};
    tick();
    wb_valid = 2'b00;
    issue_valid = 1'b1; issue_type = 2'd0; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    n_checks++; if (flush !== 1'b1 || flush_pc !== 32'h1004)
      $display("FAIL flush_pulse got f=%b pc=%h exp 1/1004", flush, flush_pc); else n_pass++;
    n_checks++; if (rob_empty !== 1'b1 || rob_tail !== 4'd0 || commit_valid !== 1'b1 || commit_rd !== 5'd0)
      $display("FAIL flush_state got empty=%b tail=%0d v=%b rd=%0d exp 1/0/1/0",
               rob_empty, rob_tail, commit_valid, commit_rd); else n_pass++;
    q1_id = 4'd1;
    tick();
    n_checks++; if (flush !== 1'b0 || rob_empty !== 1'b1 || q1_ready !== 1'b0 || commit_valid !== 1'b0)
      $display("FAIL flush_after got f=%b empty=%b q1r=%b v=%b exp 0/1/0/0",
               flush, rob_empty, q1_ready, commit_valid); else n_pass++;
    do_issue(2'd1, 5'd0, 1'b0, 32'h2000);
    wb_valid = 2'b01; wb_id = {4'd0, 4'd0}; wb_value = {32'd0, 32'h0};
    tick();
    wb_valid = 2'b00;
    tick();
    n_checks++; if (commit_valid !== 1'b1 || flush !== 1'b0 || commit_rd !== 5'd0 || rob_empty !== 1'b1)
      $display("FAIL branch_ok got v=%b f=%b rd=%0d empty=%b exp 1/0/0/1",
               commit_valid, flush, commit_rd, rob_empty); else n_pass++;
  endtask

  task automatic test_bypass();
    do_reset();
    for (int i = 0; i < 7; i++) do_issue(2'd0, 5'(i + 1), 1'b0, 32'd0);
    q1_id = 4'd5; q2_id = 4'd9;
    #1;
    n_checks++; if (q1_ready !== 1'b0 || q2_ready !== 1'b0)
      $display("FAIL query_notready got q1r=%b q2r=%b exp 0/0", q1_ready, q2_ready); else n_pass++;
    wb_valid = 2'b11; wb_id = {4'd6, 4'd5}; wb_value = {32'hBBBB, 32'hAAAA};
    q1_id = 4'd5; q2_id = 4'd6;
    #1;
    n_checks++; if (q1_ready !== 1'b1 || q1_value !== 32'hAAAA || q2_ready !== 1'b1 || q2_value !== 32'hBBBB)
      $display("FAIL bypass got q1=%b/%h q2=%b/%h exp 1/aaaa 1/bbbb", q1_ready, q1_value, q2_ready, q2_value);
    else n_pass++;
    tick();
    wb_id = {4'd4, 4'd4}; wb_value = {32'h2, 32'h1}; q1_id = 4'd4;
    #1;
    n_checks++; if (q1_ready !== 1'b1 || q1_value !== 32'h1)
      $display("FAIL bypass_collide got %b/%h exp 1/1", q1_ready, q1_value); else n_pass++;
    tick();
    wb_valid = 2'b00; q2_id = 4'd5;
    #1;
    n_checks++; if (q1_value !== 32'h1 || q2_ready !== 1'b1 || q2_value !== 32'hAAAA)
      $display("FAIL stored_values got q1=%h q2=%b/%h exp 1 1/aaaa", q1_value, q2_ready, q2_value); else n_pass++;
    wb_valid = 2'b01; wb_id = {4'd0, 4'd9}; wb_value = {32'd0, 32'h99}; q2_id = 4'd9;
    #1;
    n_checks++; if (q2_ready !== 1'b0) $display("FAIL query_unalloc got %b exp 0", q2_ready); else n_pass++;
    tick();
    wb_valid = 2'b00;
  endtask

  task automatic test_store();
    do_reset();
    do_issue(2'd2, 5'd0, 1'b0, 32'd0);
    store_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (store_commit !== 1'b1 || commit_valid !== 1'b0 || rob_empty !== 1'b0)
        $display("FAIL store_wait%0d got sc=%b v=%b empty=%b exp 1/0/0", i, store_commit, commit_valid, rob_empty);
      else n_pass++;
    end
    store_done = 1'b1;
    tick();
    store_done = 1'b0;
    n_checks++; if (commit_valid !== 1'b1 || commit_id !== 4'd0 || store_commit !== 1'b0 || rob_empty !== 1'b1)
      $display("FAIL store_retire got v=%b id=%0d sc=%b empty=%b exp 1/0/0/1",
               commit_valid, commit_id, store_commit, rob_empty); else n_pass++;
  endtask

  task automatic test_stall();
    do_reset();
    do_issue(2'd0, 5'd1, 1'b0, 32'd0);
    do_issue(2'd0, 5'd2, 1'b0, 32'd0);
    rdy_in = 1'b0;
    wb_valid = 2'b01; wb_id = {4'd0, 4'd0}; wb_value = {32'd0, 32'h77};
    tick();
    rdy_in = 1'b1;
    tick();
    rdy_in = 1'b0; issue_valid = 1'b1; wb_id = {4'd0, 4'd1}; wb_value = {32'd0, 32'h88};
    q1_id = 4'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (commit_valid !== 1'b0 || rob_tail !== 4'd2 || q1_ready !== 1'b1 || q1_value !== 32'h77)
        $display("FAIL stall%0d got v=%b tail=%0d q1=%b/%h exp 0/2/1/77", i, commit_valid, rob_tail, q1_ready, q1_value);
      else n_pass++;
    end
    rdy_in = 1'b1; issue_valid = 1'b0; wb_valid = 2'b00;
    tick();
    n_checks++; if (commit_valid !== 1'b1 || commit_rd !== 5'd1 || commit_value !== 32'h77 || rob_tail !== 4'd2)
      $display("FAIL stall_resume got v=%b rd=%0d val=%h tail=%0d exp 1/1/77/2",
               commit_valid, commit_rd, commit_value, rob_tail); else n_pass++;
    tick();
    n_checks++; if (commit_valid !== 1'b0) $display("FAIL stall_no_wb got %b exp 0", commit_valid); else n_pass++;
  endtask

  task automatic test_halt();
    do_reset();
    do_issue(2'd3, 5'd0, 1'b0, 32'd0);
    do_issue(2'd0, 5'd9, 1'b0, 32'd0);
    wb_valid = 2'b11; wb_id = {4'd1, 4'd0}; wb_value = {32'h9, 32'h0};
    tick();
    wb_valid = 2'b00;
    tick();
    n_checks++; if (halt !== 1'b1 || commit_valid !== 1'b1)
      $display("FAIL halt_set got h=%b v=%b exp 1/1", halt, commit_valid); else n_pass++;
    tick();
    n_checks++; if (halt !== 1'b1 || commit_valid !== 1'b0 || rob_empty !== 1'b0)
      $display("FAIL halt_blocks got h=%b v=%b empty=%b exp 1/0/0", halt, commit_valid, rob_empty); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_inorder_commit();
    test_full_wrap();
    test_mispredict();
    test_bypass();
    test_store();
    test_stall();
    test_halt();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
